// File: rtl/stream_arb_mux.sv
// Registered N-to-1 stream mux with round-robin / fixed-priority / forced select.
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready per channel,
//        force_en/force_sel, out_data/out_sel/out_valid/out_ready.
module stream_arb_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = 2,
  parameter int RR_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  last_grant;
  logic [NUM_CH-1:0] elig;
  logic [SEL_W-1:0]  grant;
  logic              found;
  logic              load_en;
  logic              accept;
  logic [WIDTH-1:0]  gdata;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    elig = '0;
    if (force_en) begin
      if (int'(force_sel) < NUM_CH)
        elig[force_sel] = in_valid[force_sel];
    end else begin
      elig = in_valid;
    end
  end

  // Scan order starts just after the last grant in RR mode,
  // at index 0 in fixed-priority mode; first hit wins.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] cand;
    idx   = 0;
    cand  = '0;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0)
        idx = (int'(last_grant) + 1 + k) % NUM_CH;
      else
        idx = k;
      cand = SEL_W'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (SEL_W'(k) == grant)
        gdata = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign accept = load_en && found && !rst;

  always_comb begin
    in_ready = '0;
    if (accept)
      in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_sel   <= grant;
      // Forced beats leave the round-robin pointer alone.
      if (!force_en)
        last_grant <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Self-checking bench for stream_arb_mux (round-robin and fixed-priority
// instances sharing one stimulus set).
module tb_stream_arb_mux;

  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic           force_en;
  logic [S-1:0]   force_sel;
  logic           out_ready;

  logic [N-1:0] rr_in_ready;
  logic [W-1:0] rr_out_data;
  logic [S-1:0] rr_out_sel;
  logic         rr_out_valid;
  logic [N-1:0] fp_in_ready;
  logic [W-1:0] fp_out_data;
  logic [S-1:0] fp_out_sel;
  logic         fp_out_valid;

  stream_arb_mux #(.WIDTH(W), .NUM_CH(N), .SEL_W(S), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(rr_out_data), .out_sel(rr_out_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  stream_arb_mux #(.WIDTH(W), .NUM_CH(N), .SEL_W(S), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(fp_out_data), .out_sel(fp_out_sel),
    .out_valid(fp_out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [S-1:0] sel;
    logic [W-1:0] data;
  } beat_t;

  beat_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    m_last = N - 1;
  bit    m_ov   = 1'b0;

  // One clock cycle: predict grant for the RR instance, check in_ready,
  // update the scoreboard, then check the registered output.
  task automatic step();
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    bit           load;
    int           g;
    beat_t        b;
    #1;
    load = !m_ov || out_ready;
    elig = '0;
    if (force_en) elig[force_sel] = in_valid[force_sel];
    else elig = in_valid;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (g < 0 && elig[i]) g = i;
    end
    exp_rdy = '0;
    if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
    checks++;
    if (rr_in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", rr_in_ready, exp_rdy);
    end
    if (m_ov && out_ready && !rst && sbq.size() > 0) void'(sbq.pop_front());
    if (exp_rdy != '0) begin
      b.sel  = S'(g);
      b.data = in_data[g*W +: W];
      sbq.push_back(b);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_ov   = 1'b0;
      m_last = N - 1;
      sbq.delete();
    end else if (exp_rdy != '0) begin
      m_ov = 1'b1;
      if (!force_en) m_last = g;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    checks++;
    if (rr_out_valid !== m_ov) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", rr_out_valid, m_ov);
    end
    if (m_ov) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: empty while out_valid expected");
      end else if (rr_out_data !== sbq[0].data || rr_out_sel !== sbq[0].sel) begin
        errors++;
        $display("FAIL beat: got sel=%0d data=%h expected sel=%0d data=%h",
                 rr_out_sel, rr_out_data, sbq[0].sel, sbq[0].data);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = '1;
    in_data   = {32'h4, 32'h3, 32'h2, 32'h1};
    out_ready = 1'b1;
    force_en  = 1'b0;
    force_sel = '0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (rr_in_ready !== 4'b0000 || fp_in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b expected 0000", rr_in_ready, fp_in_ready);
    end
    checks++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== '0 || rr_out_sel !== '0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h s=%0d expected 0/0/0",
               rr_out_valid, rr_out_data, rr_out_sel);
    end
    rst = 1'b0;
    step();
    checks++;
    if (rr_out_sel !== 2'd0 || rr_out_data !== 32'h1) begin
      errors++;
      $display("FAIL reset_first: got sel=%0d expected 0", rr_out_sel);
    end
  endtask

  task automatic test_rr_sweep();
    logic [31:0] dat [4];
    int          exp_sel [5];
    dat     = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
    exp_sel = '{0, 1, 2, 3, 0};
    do_reset();
    in_data   = {dat[3], dat[2], dat[1], dat[0]};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== S'(exp_sel[i]) ||
          rr_out_data !== dat[exp_sel[i]]) begin
        errors++;
        $display("FAIL rr_sweep[%0d]: got v=%b sel=%0d d=%h expected sel=%0d",
                 i, rr_out_valid, rr_out_sel, rr_out_data, exp_sel[i]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    in_data   = {32'h33, 32'h22, 32'h11, 32'h00};
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_in_ready !== 4'b0010) begin
        errors++;
        $display("FAIL fixed_prio[%0d]: got sel=%0d rdy=%b expected 1/0010",
                 i, fp_out_sel, fp_in_ready);
      end
    end
    in_valid = 4'b1000;
    step();
    checks++;
    if (fp_out_sel !== 2'd3 || fp_out_data !== 32'h33) begin
      errors++;
      $display("FAIL fixed_prio_next: got sel=%0d expected 3", fp_out_sel);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data   = {32'hDD, 32'h12345678, 32'hBB, 32'hAA};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd2 ||
          rr_out_data !== 32'h12345678 || rr_in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b sel=%0d d=%h rdy=%b", i,
                 rr_out_valid, rr_out_sel, rr_out_data, rr_in_ready);
      end
    end
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    step();
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 32'hAA) begin
      errors++;
      $display("FAIL hold_release: got sel=%0d d=%h expected 0/aa",
               rr_out_sel, rr_out_data);
    end
  endtask

  task automatic test_forced();
    do_reset();
    in_data   = {32'h43, 32'h42, 32'h41, 32'h40};
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    step();
    force_en  = 1'b1;
    force_sel = 2'd3;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rr_out_sel !== 2'd3 || rr_in_ready !== 4'b1000) begin
        errors++;
        $display("FAIL forced[%0d]: got sel=%0d rdy=%b expected 3/1000",
                 i, rr_out_sel, rr_in_ready);
      end
    end
    force_en = 1'b0;
    step();
    checks++;
    if (rr_out_sel !== 2'd1 || rr_out_data !== 32'h41) begin
      errors++;
      $display("FAIL forced_release: got sel=%0d expected 1", rr_out_sel);
    end
  endtask

  task automatic test_reset_mid();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if (rr_out_valid !== 1'b0 || fp_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b/%b expected 0", rr_out_valid, fp_out_valid);
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (rr_out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_first: got sel=%0d expected 0", rr_out_sel);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      in_valid  = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      force_en  = ($urandom_range(0, 4) == 0);
      force_sel = S'($urandom_range(0, 3));
      for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_rr_sweep();
    test_fixed_priority();
    test_backpressure();
    test_forced();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_arb_mux.md
# stream_arb_mux

Parametrised, registered N-to-1 multiplexer with valid/ready handshakes on every input channel and on the output. It generalises the datapath 4:1 select mux to NUM_CH channels of WIDTH bits. Selection is either arbitrated (round-robin or fixed-priority) or forced by an explicit select, as the plain mux did. The block sits between multiple producers, such as load/store or debug requesters, and a single shared consumer. It has one output register stage and full throughput.

## Interface
- WIDTH, 32, data width per channel
- NUM_CH, 4, number of input channels (≥2)
- SEL_W, 2, select/grant index width; must equal $clog2(NUM_CH)
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready (one-hot or zero)
- force_en  input  1  1 = only channel force_sel is eligible
- force_sel  input  SEL_W  forced channel index
- out_data  output  WIDTH  registered data
- out_sel  output  SEL_W  index of channel that supplied out_data
- out_valid  output  1  output beat present
- out_ready  input  1  consumer accepts beat

## Operation
- Reset values: out_valid=0, out_data=0, out_sel=0, last_grant=NUM_CH-1, so channel 0 has first round-robin priority.
- load_en = !out_valid || out_ready. The output register can take a new beat whenever it is empty or is being drained in the same cycle.
- Eligible set:
  - If force_en=1, the set is in_valid[force_sel] only.
  - If force_sel ≥ NUM_CH, the set is empty.
  - Otherwise the set is all asserted in_valid bits.
- Grant, computed combinationally from the eligible set:
  - RR_MODE=1: the first eligible index found by scanning from last_grant+1 upward, wrapping modulo NUM_CH.
  - RR_MODE=0: the lowest eligible index.
- in_ready[g] = load_en && eligible-set non-empty, where g is the grant. All other in_ready bits are 0. There is never more than one ready bit set.
- Accept occurs when in_valid[g] && in_ready[g]. On accept, at the clock edge:
  - out_data is loaded with channel g's data.
  - out_sel is set to g.
  - out_valid is set to 1.
  - last_grant is set to g, but only when force_en=0. Forced transfers do not move the round-robin pointer.
- Drain without accept: out_valid && out_ready with no accept sets out_valid to 0. out_data and out_sel hold their last values.
- Hold: out_valid && !out_ready keeps out_data, out_sel and out_valid stable, and drives every in_ready bit to 0.
- Simultaneous drain and accept: the new beat replaces the old one in the same edge and out_valid stays 1. This gives back-to-back beats with no bubble.
- Reset mid-transfer: a beat held in the register is discarded. out_valid is 0 on the cycle after rst. No in_ready is asserted while rst=1.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on out_data with out_valid=1 after edge k.
- Throughput is 1 beat per cycle while out_ready=1 and any eligible channel is valid.
- in_ready depends combinationally on out_ready, out_valid, in_valid, force_en and force_sel.
- in_ready has no combinational dependence on in_data.
- out_* are driven purely from registers; there is no combinational path from any input to out_*.
- Round-robin fairness: with all NUM_CH channels continuously valid, out_ready=1 and force_en=0, grants cycle 0,1,…,NUM_CH-1,0,… Every channel is served within NUM_CH accepts.
- Pointer wrap: when last_grant=NUM_CH-1, the next scan starts at 0.

## Test plan
- Reset and idle:
  - Stimulus: assert rst with all in_valid=1.
  - Required: in_ready=0000, out_valid=0, out_data=0, out_sel=0 on the cycle after reset.
  - Then: deassert rst; the first accept is channel 0.
- Round-robin sweep:
  - Setup: defaults, in_data channels = 0xA0,0xB1,0xC2,0xD3, all valid, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0 on consecutive cycles with the matching data, and no bubbles.
- Fixed priority:
  - Setup: RR_MODE=0, in_valid=1010, out_ready=1 for 3 cycles.
  - Required: channel 1 is granted every cycle and channel 3 is never granted.
  - Then: clear in_valid[1]; the next grant is channel 3.
- Backpressure hold:
  - Stimulus: accept 0x12345678 from channel 2, then hold out_ready=0 for 4 cycles.
  - Required: out_data=0x12345678, out_sel=2 and out_valid=1 stay constant, in_ready=0000 throughout.
  - Then: raise out_ready; the next beat appears after 1 cycle.
- Forced select:
  - Setup: force_en=1, force_sel=3, all valid, last_grant=0.
  - Required: only in_ready[3] is asserted, and out_sel=3 on every beat.
  - Then: drop force_en; the round-robin grant is channel 1, because the pointer was unchanged by the forced transfers.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid=1 and out_ready=0.
  - Required: out_valid=0 on the next cycle, and last_grant returns to NUM_CH-1, so the first grant after reset is channel 0.
